// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters beside the fetch PC.
// Define BP_GSHARE_EN to index a separate pattern table with idx ^ global history.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned HIST_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jmp,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    if (ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("ENTRIES must be a power of two >= 2");
    end
    if (IDX_W + TAG_W + 2 > 32 || HIST_W > IDX_W || HIST_W < 1) begin : g_bad_widths
        $error("illegal TAG_W/HIST_W for this ENTRIES");
    end

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic             jmp_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    // Per-entry counters by default; the gshare pattern table when enabled.
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] lookups_q, lookups_d;
    logic [31:0] mispred_q, mispred_d;

    logic [IDX_W-1:0] f_idx, f_cidx, u_idx, u_cidx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, mispredict;
    logic [1:0]       ctr_d;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc, upd_pc};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghist_q, ghist_d;
    logic [HIST_W:0]   ghist_ext;

    assign f_cidx    = f_idx ^ IDX_W'(ghist_q);
    assign u_cidx    = u_idx ^ IDX_W'(ghist_q);
    assign ghist_ext = {ghist_q, upd_taken};
    assign ghist_d   = ghist_ext[HIST_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ghist_q <= '0;
        end else if (upd_valid && !upd_is_jmp) begin
            ghist_q <= ghist_d;
        end
    end
`else
    assign f_cidx = f_idx;
    assign u_cidx = u_idx;
`endif

    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = !reset && f_hit && (jmp_q[f_idx] || ctr_q[f_cidx][1]);
        pred_target = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        ctr_d = ctr_q[u_cidx];
        if (upd_taken && ctr_q[u_cidx] != 2'b11) begin
            ctr_d = ctr_q[u_cidx] + 2'b01;
        end else if (!upd_taken && ctr_q[u_cidx] != 2'b00) begin
            ctr_d = ctr_q[u_cidx] - 2'b01;
        end
        mispredict = (upd_pred_taken != upd_taken) ||
                     (upd_taken && upd_pred_target != upd_target);
        lookups_d  = (lookups_q == '1) ? lookups_q : lookups_q + 32'd1;
        mispred_d  = mispred_q;
        if (mispredict && mispred_q != '1) begin
            mispred_d = mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            lookups_q <= '0;
            mispred_q <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_cidx] <= ctr_d;
                jmp_q[u_idx]  <= upd_is_jmp;
                if (upd_taken) begin
                    target_q[u_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                jmp_q[u_idx]    <= upd_is_jmp;
                target_q[u_idx] <= upd_target;
                ctr_q[u_cidx]   <= 2'b10;
            end
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default parameters); honours BP_GSHARE_EN.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jmp;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned wrong  = 0;
    logic        p_t;
    logic [31:0] p_tgt;

    branch_predictor #(.ENTRIES(64), .TAG_W(8), .HIST_W(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_jmp       (upd_is_jmp),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_pc          = pc;
        upd_is_jmp      = jmp;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        upd_valid       = 1'b1;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0; upd_is_jmp = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        tick();
        #1;
        check("rst_held_taken", 32'(pred_taken), 32'd0);
        check("rst_held_target", pred_target, 32'h44);
        reset = 1'b0;
        #1;
        check("rst_taken", 32'(pred_taken), 32'd0);
        check("rst_target", pred_target, 32'h44);
        check("rst_lookups", stat_lookups, 32'd0);
        check("rst_mispred", stat_mispredicts, 32'd0);

`ifndef BP_GSHARE_EN
        // Allocation on a taken miss, weakly taken
        upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        check("alloc_taken", 32'(pred_taken), 32'd1);
        check("alloc_target", pred_target, 32'h100);
        check("alloc_lookups", stat_lookups, 32'd1);
        check("alloc_mispred", stat_mispredicts, 32'd1);

        // Idle cycle with garbage update fields changes nothing
        upd_pc = 32'h40; upd_taken = 1'b0; upd_target = 32'hDEAD; upd_pred_taken = 1'b1;
        tick();
        check("idle_taken", 32'(pred_taken), 32'd1);
        check("idle_target", pred_target, 32'h100);
        check("idle_lookups", stat_lookups, 32'd1);

        // Counter: 10 -> 01 -> 00 -> 01 -> 10
        upd(32'h40, 1'b0, 1'b0, 32'h44, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 1'b0, 32'h44, 1'b0, 32'h44);
        check("ctr00_taken", 32'(pred_taken), 32'd0);
        check("ctr00_target", pred_target, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        check("ctr01_taken", 32'(pred_taken), 32'd0);
        upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        check("ctr10_taken", 32'(pred_taken), 32'd1);
        check("ctr10_target", pred_target, 32'h100);
        check("ctr_lookups", stat_lookups, 32'd5);
        check("ctr_mispred", stat_mispredicts, 32'd4);

        // Jump entry ignores the counter
        upd(32'h40, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 1'b0, 32'h44, 1'b1, 32'h200);
        check("jmp_taken", 32'(pred_taken), 32'd1);
        check("jmp_target", pred_target, 32'h200);
        check("jmp_mispred", stat_mispredicts, 32'd9);
        fetch_pc = 32'h140;
        #1;
        check("alias_taken", 32'(pred_taken), 32'd0);
        check("alias_target", pred_target, 32'h144);

        // Same-cycle lookup sees pre-update contents
        fetch_pc = 32'h40;
        upd_pc = 32'h40; upd_is_jmp = 1'b0; upd_taken = 1'b0; upd_target = 32'h44;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h200; upd_valid = 1'b1;
        #1;
        check("same_cyc_taken", 32'(pred_taken), 32'd1);
        check("same_cyc_target", pred_target, 32'h200);
        tick();
        upd_valid = 1'b0;
        check("after_upd_taken", 32'(pred_taken), 32'd0);
        check("after_upd_target", pred_target, 32'h44);
        check("after_upd_lookups", stat_lookups, 32'd11);
        check("after_upd_mispred", stat_mispredicts, 32'd10);
`endif

        // Reset wins over a concurrent update and flushes everything
        reset = 1'b1;
        upd(32'h80, 1'b1, 1'b1, 32'h300, 1'b0, 32'h84);
        reset = 1'b0;
        fetch_pc = 32'h80;
        #1;
        check("rstupd_taken", 32'(pred_taken), 32'd0);
        check("rstupd_target", pred_target, 32'h84);
        check("rstupd_lookups", stat_lookups, 32'd0);
        check("rstupd_mispred", stat_mispredicts, 32'd0);
        fetch_pc = 32'h40;
        #1;
        check("flushed_taken", 32'(pred_taken), 32'd0);

        // Alternating T/N branch at 0x80, score the last 8 predictions
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'h80;
            #1;
            p_t   = pred_taken;
            p_tgt = pred_target;
            if (i >= 8 && p_t != (i % 2 == 0)) wrong++;
            upd(32'h80, 1'b0, (i % 2 == 0), 32'h300, p_t, p_tgt);
        end
`ifdef BP_GSHARE_EN
        check("alt_wrong", wrong, 32'd0);
`else
        check("alt_wrong_ge4", 32'(wrong >= 4), 32'd1);
`endif
        check("alt_lookups", stat_lookups, 32'd16);

        // PC + 4 wraps at the top of the address space
        fetch_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_target", pred_target, 32'h0);
        upd(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
        check("wrap_hit_taken", 32'(pred_taken), 32'd1);
        check("wrap_hit_target", pred_target, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
